// File: rtl/alexcpt_wr_ctrl.sv
// Active-list exception RAM write controller: post-reset/flush clear, then round-robin write arbitration.
// Optional macro ALEXCPT_PART_GATE_EN adds partition gating of clearing and requester writes.
module alexcpt_wr_ctrl #(
  parameter int DEPTH     = 16,
  parameter int INDEX     = 4,
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int NUM_PARTS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef ALEXCPT_PART_GATE_EN
  input  logic [NUM_PARTS-1:0]           alPartitionActive_i,
`endif
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             reqValid_i,
  input  logic [NUM_REQ-1:0][INDEX-1:0]  reqAddr_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]  reqData_i,
  output logic [NUM_REQ-1:0]             reqReady_o,
  output logic [INDEX-1:0]               addr0wr_o,
  output logic [INDEX-1:0]               addr1wr_o,
  output logic [WIDTH-1:0]               data0wr_o,
  output logic [WIDTH-1:0]               data1wr_o,
  output logic                           we0_o,
  output logic                           we1_o,
  output logic                           ramReady_o
);

  localparam int RRW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW        = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
  localparam int PART_SIZE = DEPTH / NUM_PARTS;
  localparam logic [INDEX:0] DEPTH_W = (INDEX+1)'(DEPTH);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [INDEX-1:0]       clear_ptr_r, clear_ptr_nxt_s;
  logic [RRW-1:0]         rr_ptr_r, rr_ptr_nxt_s;
  logic                   we0_r, we1_r, we0_nxt_s, we1_nxt_s;
  logic [INDEX-1:0]       addr0_r, addr1_r, addr0_nxt_s, addr1_nxt_s;
  logic [WIDTH-1:0]       data0_r, data1_r, data0_nxt_s, data1_nxt_s;
  logic                   ram_ready_r, ram_ready_nxt_s;
  logic [NUM_REQ-1:0]     ready_s;
  logic [NUM_PARTS-1:0]   part_active_s;
  logic [DEPTH-1:0]       ent_active_s;
  logic                   g0_v_s, g1_v_s;
  logic [RRW-1:0]         g0_idx_s, g1_idx_s;
  logic [INDEX:0]         base_s, hit_s, next_hit_s;

`ifdef ALEXCPT_PART_GATE_EN
  assign part_active_s = alPartitionActive_i;
`else
  assign part_active_s = {NUM_PARTS{1'b1}};
`endif

  // First even entry at or above start that lies in an active partition; DEPTH when none remain.
  function automatic logic [INDEX:0] find_active(input logic [INDEX:0] start,
                                                 input logic [DEPTH-1:0] ent);
    logic [INDEX:0] res;
    res = DEPTH_W;
    for (int e = DEPTH - 2; e >= 0; e = e - 2) begin
      res = (((INDEX+1)'(e) >= start) && ent[INDEX'(e)]) ? (INDEX+1)'(e) : res;
    end
    return res;
  endfunction

  // Requester slot reached k steps above the round-robin pointer.
  function automatic logic [RRW-1:0] scan_idx(input logic [RRW-1:0] ptr, input int k);
    return RRW'((int'(ptr) + k) % NUM_REQ);
  endfunction

  // Per-entry activity mask expanded from the partition enables.
  always_comb begin
    ent_active_s = '0;
    for (int e = 0; e < DEPTH; e++) begin
      ent_active_s[INDEX'(e)] = part_active_s[PW'(e / PART_SIZE)];
    end
  end

  // Round-robin scan: first two valid requesters above rr_ptr_r take ports 0 and 1.
  always_comb begin
    g0_v_s   = 1'b0;
    g1_v_s   = 1'b0;
    g0_idx_s = '0;
    g1_idx_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (reqValid_i[scan_idx(rr_ptr_r, k)] && !g0_v_s) begin
        g0_v_s   = 1'b1;
        g0_idx_s = scan_idx(rr_ptr_r, k);
      end else if (reqValid_i[scan_idx(rr_ptr_r, k)] && !g1_v_s) begin
        g1_v_s   = 1'b1;
        g1_idx_s = scan_idx(rr_ptr_r, k);
      end else begin
        g1_v_s   = g1_v_s;
      end
    end
  end

  // Next-state, clear sequencing, grants and next port values.
  always_comb begin
    state_nxt_s     = state_r;
    clear_ptr_nxt_s = clear_ptr_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    we0_nxt_s       = 1'b0;
    we1_nxt_s       = 1'b0;
    addr0_nxt_s     = '0;
    addr1_nxt_s     = '0;
    data0_nxt_s     = '0;
    data1_nxt_s     = '0;
    ram_ready_nxt_s = 1'b0;
    ready_s         = '0;
    base_s          = '0;
    hit_s           = DEPTH_W;
    next_hit_s      = DEPTH_W;
    case (state_r)
      CLEAR: begin
        base_s = flush_i ? '0 : {1'b0, clear_ptr_r};
        hit_s  = find_active(base_s, ent_active_s);
        if (hit_s == DEPTH_W) begin
          state_nxt_s     = READY;
          clear_ptr_nxt_s = '0;
        end else begin
          we0_nxt_s   = 1'b1;
          we1_nxt_s   = 1'b1;
          addr0_nxt_s = hit_s[INDEX-1:0];
          addr1_nxt_s = hit_s[INDEX-1:0] + INDEX'(1);
          next_hit_s  = find_active(hit_s + (INDEX+1)'(2), ent_active_s);
          if (next_hit_s == DEPTH_W) begin
            state_nxt_s     = READY;
            clear_ptr_nxt_s = '0;
          end else begin
            state_nxt_s     = CLEAR;
            clear_ptr_nxt_s = next_hit_s[INDEX-1:0];
          end
        end
      end
      READY: begin
        if (flush_i) begin
          state_nxt_s     = CLEAR;
          clear_ptr_nxt_s = '0;
        end else begin
          ram_ready_nxt_s = 1'b1;
          if (g0_v_s) begin
            ready_s[g0_idx_s] = 1'b1;
            we0_nxt_s         = ent_active_s[reqAddr_i[g0_idx_s]];
            addr0_nxt_s       = reqAddr_i[g0_idx_s];
            data0_nxt_s       = reqData_i[g0_idx_s];
          end else begin
            we0_nxt_s         = 1'b0;
          end
          if (g1_v_s) begin
            ready_s[g1_idx_s] = 1'b1;
            we1_nxt_s         = ent_active_s[reqAddr_i[g1_idx_s]];
            addr1_nxt_s       = reqAddr_i[g1_idx_s];
            data1_nxt_s       = reqData_i[g1_idx_s];
            rr_ptr_nxt_s      = scan_idx(g1_idx_s, 1);
          end else if (g0_v_s) begin
            rr_ptr_nxt_s      = scan_idx(g0_idx_s, 1);
          end else begin
            rr_ptr_nxt_s      = rr_ptr_r;
          end
        end
      end
      default: begin
        state_nxt_s     = CLEAR;
        clear_ptr_nxt_s = '0;
      end
    endcase
  end

  assign reqReady_o = ready_s;

  // State and registered RAM port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= CLEAR;
      clear_ptr_r <= '0;
      rr_ptr_r    <= '0;
      we0_r       <= 1'b0;
      we1_r       <= 1'b0;
      addr0_r     <= '0;
      addr1_r     <= '0;
      data0_r     <= '0;
      data1_r     <= '0;
      ram_ready_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clear_ptr_r <= clear_ptr_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      we0_r       <= we0_nxt_s;
      we1_r       <= we1_nxt_s;
      addr0_r     <= addr0_nxt_s;
      addr1_r     <= addr1_nxt_s;
      data0_r     <= data0_nxt_s;
      data1_r     <= data1_nxt_s;
      ram_ready_r <= ram_ready_nxt_s;
    end
  end

  assign we0_o      = we0_r;
  assign we1_o      = we1_r;
  assign addr0wr_o  = addr0_r;
  assign addr1wr_o  = addr1_r;
  assign data0wr_o  = data0_r;
  assign data1wr_o  = data1_r;
  assign ramReady_o = ram_ready_r;

endmodule
